// File: rtl/quad_pkg.sv
// Shared constants and the Gray-code transition classifier for the quadrature step decoder.
package quad_pkg;

    localparam logic [1:0] S00 = 2'b00;
    localparam logic [1:0] S01 = 2'b01;
    localparam logic [1:0] S11 = 2'b11;
    localparam logic [1:0] S10 = 2'b10;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    // Filter and priming counters; wide enough for FILT_LEN up to 15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        MV_NONE,
        MV_FWD,
        MV_REV,
        MV_ILL
    } move_e;

    function automatic logic [1:0] fwd_next(input logic [1:0] s);
        case (s)
            S00:     fwd_next = S01;
            S01:     fwd_next = S11;
            S11:     fwd_next = S10;
            default: fwd_next = S00;
        endcase
    endfunction

    // A single-bit change that is not the forward neighbour must be the reverse one.
    function automatic move_e classify(input logic [1:0] old_s, input logic [1:0] new_s);
        if (old_s == new_s)
            classify = MV_NONE;
        else if ((old_s ^ new_s) == 2'b11)
            classify = MV_ILL;
        else if (fwd_next(old_s) == new_s)
            classify = MV_FWD;
        else
            classify = MV_REV;
    endfunction

endpackage

// File: rtl/quad_filter.sv
// One quadrature channel: 2-flop synchronizer followed by a stability counter that
// only lets the filtered value follow after FILT_LEN consecutive differing samples.
module quad_filter
    import quad_pkg::*;
#(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filt,
    output logic stable
);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    // The load happens on the cycle the count would reach FILT_LEN, so the
    // filtered value moves exactly FILT_LEN cycles after the synced edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= '0;
            filt <= 1'b0;
            cnt  <= '0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == filt) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(FILT_LEN - 1)) begin
                filt <= sync[1];
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Whole chain agrees: nothing in flight that could still move filt.
    assign stable = (sync[1] == filt) && (sync[0] == sync[1]);

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature A/B decoder: filtered channels, priming after reset, step/dir/err pulses.
// Define QUAD_ERR_CNT_EN to add err_clr/err_cnt (saturating illegal-transition count).
module quad_step_decoder
    import quad_pkg::*;
#(
    parameter int FILT_LEN = 3,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             a_in,
    input  logic             b_in,
    output logic             step_en,
    output logic             step_dir,
    output logic             err,
    output logic [1:0]       ab_state
`ifdef QUAD_ERR_CNT_EN
    ,
    input  logic             err_clr,
    output logic [ERR_W-1:0] err_cnt
`endif
);

    logic [1:0]       raw;
    logic [1:0]       filt_ab;
    logic [1:0]       stable;
    logic [CNT_W-1:0] prime_cnt;
    logic             primed;

    assign raw = {a_in, b_in};

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        quad_filter #(.FILT_LEN(FILT_LEN)) u_filt (
            .clk    (clk),
            .rst    (rst),
            .raw    (raw[ch]),
            .filt   (filt_ab[ch]),
            .stable (stable[ch])
        );
    end

    // Until primed, ab_state waits for both channels to settle and then adopts
    // the pin levels silently, so non-00 pins out of reset never look illegal.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prime_cnt <= '0;
            primed    <= 1'b0;
            ab_state  <= S00;
            step_en   <= 1'b0;
            step_dir  <= DIR_FWD;
            err       <= 1'b0;
        end else begin
            step_en <= 1'b0;
            err     <= 1'b0;
            if (!primed) begin
                if (!(&stable)) begin
                    prime_cnt <= '0;
                end else if (prime_cnt == CNT_W'(FILT_LEN - 1)) begin
                    primed    <= 1'b1;
                    ab_state  <= filt_ab;
                    prime_cnt <= '0;
                end else begin
                    prime_cnt <= prime_cnt + 1'b1;
                end
            end else begin
                ab_state <= filt_ab;
                case (classify(ab_state, filt_ab))
                    MV_FWD: begin
                        step_en  <= en;
                        step_dir <= DIR_FWD;
                    end
                    MV_REV: begin
                        step_en  <= en;
                        step_dir <= DIR_REV;
                    end
                    MV_ILL:  err <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

`ifdef QUAD_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err_cnt <= '0;
        else if (err_clr)
            err_cnt <= '0;
        else if (err && (err_cnt != '1))
            err_cnt <= err_cnt + 1'b1;
    end
`endif

endmodule
